reg_dump_unit: RTL
==================

Name: reg_dump_unit

Overview:
Hardware snapshot/dump engine for the pipelined MIPS core. It performs in hardware the job the directed test benches do by hierarchical peeking. It counts cycles from reset and, when an armed trigger cycle is reached, captures PC and the EX-stage ALU result. It then walks a range of register-file entries through a dedicated read port and streams every value out over a valid/ready channel. It sits beside Top's register file and feeds a debug/trace sink.

Parameters:
DATA_W, 32, width of PC, ALU result, register data and dump data
ADDR_W, 5, register-file address width (32 registers)
CYC_W, 32, cycle counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
arm  in  1  single-cycle pulse; arms the trigger using the current config inputs
trig_cycle  in  CYC_W  cycle number at which the snapshot fires
first_reg  in  ADDR_W  first register index to dump
last_reg  in  ADDR_W  last register index to dump (inclusive)
pc_in  in  DATA_W  current program_counter
aluout_in  in  DATA_W  current ALUOut_EXEC
rf_rd_addr  out  ADDR_W  debug read address to register file
rf_rd_data  in  DATA_W  combinational read data for rf_rd_addr
dump_valid  out  1  beat valid
dump_ready  in  1  sink accepts beat
dump_tag  out  8  beat identity: 0x40=PC, 0x41=ALU, 0x80|idx=register idx, 0xFF=checksum
dump_data  out  DATA_W  beat payload
cycle_count  out  CYC_W  current cycle number
busy  out  1  armed or dumping
done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (async, rst=1): cycle_count=1; state=IDLE; dump_valid=0; dump_tag=0; dump_data=0; rf_rd_addr=0; busy=0; done=0.
- cycle_count increments by 1 every clk after reset and saturates at all-ones.
- arm, first_reg, last_reg and trig_cycle are sampled together when arm=1 in IDLE or DONE. arm is ignored in every other state.
- States:
  - IDLE: wait for arm.
  - ARMED: when cycle_count >= trig_cycle, register pc_in and aluout_in into snapshot registers at that edge, then go to SEND_PC. A trigger already in the past fires on the cycle after arming.
  - SEND_PC: tag 0x40. Go to SEND_ALU on handshake.
  - SEND_ALU: tag 0x41. On handshake go to READ_REG, or to FINISH if first_reg > last_reg.
  - READ_REG: drive rf_rd_addr=idx and register rf_rd_data at the edge. Always exactly 1 cycle. Go to SEND_REG.
  - SEND_REG: tag 0x80|idx. On handshake, if idx==last_reg go to FINISH; otherwise idx+1 and go to READ_REG.
  - FINISH: pulse done, go to DONE.
  - DONE: hold until arm.
- Handshake: a beat transfers when dump_valid & dump_ready are high at a clk edge. Once raised, valid stays high and tag/data stay stable until the transfer. Valid never depends combinationally on ready.
- Register values come from live register-file contents at read time. PC and ALU values are frozen at the trigger edge.
- idx never wraps: last_reg=31 ends the walk without incrementing past 31.
- busy=1 in ARMED through FINISH.
- rst asserted mid-dump aborts at once to the reset values. There are no partial-beat guarantees.
- Beat count with first<=last: 2 + (last-first+1), plus the checksum beat if enabled.

Optional Feature:
REG_DUMP_CHECKSUM_EN
- Defined: FINISH is preceded by a SEND_CSUM beat with tag 0xFF and data equal to the XOR of all previous beat data in this dump. The accumulator clears at the trigger.
- Undefined: no checksum beat and no accumulator logic.

Decomposition:
- Package reg_dump_pkg holds:
  - the state enum;
  - tag constants TAG_PC=8'h40, TAG_ALU=8'h41, TAG_REG_BASE=8'h80, TAG_CSUM=8'hFF;
  - default widths.
- One natural sub-module: dump_out_reg, a single-entry valid/ready output holding register (load when empty or on transfer).

Test Plan:
- Core started at PC 700; arm with trig=9, first=19, last=23, ready=1 -> beats are:
  - PC(0x40), then ALU(0x41);
  - 0x93=15, 0x94=20, 0x95=21, 0x96=22, 0x97=43;
  - done pulses once and busy drops.
- Same run with ready toggling 1010… -> identical beat sequence, and tag/data stay stable while valid is high and ready is low.
- Arm with trig=3 when cycle_count=20 -> snapshot fires the cycle after arming.
- first=5, last=2 -> exactly two beats (PC, ALU), then done.
- first=last=31 -> one register beat, tag 0x9F, no wrap.
- rst mid-stream after the third beat -> dump_valid=0 and cycle_count=1 immediately; re-arm produces a full fresh dump.
- With REG_DUMP_CHECKSUM_EN: final beat tag 0xFF, data equal to the XOR of the preceding beats.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register snapshot/dump engine: default widths,
// beat tag encodings and the sequencer state type.
// Optional feature macro: REG_DUMP_CHECKSUM_EN (adds a trailing XOR beat).
package reg_dump_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CYC_W  = 32;

  localparam logic [7:0] TAG_PC       = 8'h40;
  localparam logic [7:0] TAG_ALU      = 8'h41;
  localparam logic [7:0] TAG_REG_BASE = 8'h80;
  localparam logic [7:0] TAG_CSUM     = 8'hFF;

  // Dump sequencer states. SEND_CSUM is only reachable when the checksum
  // beat is built in.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SEND_PC,
    ST_SEND_ALU,
    ST_READ_REG,
    ST_SEND_REG,
    ST_SEND_CSUM,
    ST_FINISH,
    ST_DONE
  } dump_state_t;

  // Tag for a register beat: the register index lives in the low bits.
  function automatic logic [7:0] regTag(input logic [7:0] idx);
    return TAG_REG_BASE | idx;
  endfunction

endpackage

// File: rtl/reg_dump_unit_out_reg.sv
// Single-entry valid/ready holding register for the dump stream. It accepts
// a new beat when it is empty or when its current beat is leaving, so valid
// is always a registered signal and never a function of the sink's ready.
module dump_out_reg
  import reg_dump_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [7:0]        i_tag,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [7:0]        o_tag,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready
);

  logic              r_valid;
  logic [7:0]        r_tag;
  logic [DATA_W-1:0] r_data;
  logic              w_load;

  assign o_ready = !r_valid || i_ready;
  assign w_load  = i_valid && o_ready;

  // Hold the beat steady until the sink takes it; tag/data keep their last
  // value after the transfer since valid alone qualifies them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_tag   <= i_tag;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_tag   = r_tag;
  assign o_data  = r_data;

endmodule

// File: rtl/reg_dump_unit.sv
// Hardware snapshot/dump engine. Counts cycles from reset; once armed it
// waits for the trigger cycle, freezes PC and the EX-stage ALU result, then
// walks a register range through a private read port and streams every
// value out as tagged beats over a valid/ready channel.
// Optional feature macro: REG_DUMP_CHECKSUM_EN -- appends a beat carrying the
// XOR of all earlier beat payloads of the dump.
module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CYC_W  = DEF_CYC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [CYC_W-1:0]  trig_cycle,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] aluout_in,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [7:0]        dump_tag,
  output logic [DATA_W-1:0] dump_data,
  output logic [CYC_W-1:0]  cycle_count,
  output logic              busy,
  output logic              done
);

  dump_state_t       r_state;
  dump_state_t       w_next;

  logic [CYC_W-1:0]  r_cycle;
  logic [CYC_W-1:0]  r_trig;
  logic [ADDR_W-1:0] r_first;
  logic [ADDR_W-1:0] r_last;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_pcSnap;
  logic [DATA_W-1:0] r_aluSnap;
  logic [DATA_W-1:0] r_regData;

  logic              w_armAccept;
  logic              w_fire;
  logic              w_xfer;
  logic              w_bufReady;
  logic              w_slotFree;
  logic              w_push;
  logic [7:0]        w_pushTag;
  logic [DATA_W-1:0] w_pushData;
  dump_state_t       w_afterLast;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  assign w_afterLast = ST_SEND_CSUM;
`else
  assign w_afterLast = ST_FINISH;
`endif

  assign w_armAccept = arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_fire      = (r_state == ST_ARMED) && (r_cycle >= r_trig);
  assign w_xfer      = dump_valid && dump_ready;
  // A send state issues its beat only into an empty holding register, so
  // every beat is pushed exactly once and the state then waits for the
  // sink to take it.
  assign w_slotFree  = w_bufReady && !dump_valid;

  // Free-running cycle counter, starting at 1 out of reset and sticking at
  // all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle <= CYC_W'(1);
    end else if (r_cycle != {CYC_W{1'b1}}) begin
      r_cycle <= r_cycle + CYC_W'(1);
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and beat issue: each send state offers one beat and
  // advances only when that beat leaves on the output channel.
  always_comb begin
    w_next     = r_state;
    w_push     = 1'b0;
    w_pushTag  = '0;
    w_pushData = '0;
    case (r_state)
      ST_IDLE: begin
        if (arm) w_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_fire) w_next = ST_SEND_PC;
      end
      ST_SEND_PC: begin
        w_push     = w_slotFree;
        w_pushTag  = TAG_PC;
        w_pushData = r_pcSnap;
        if (w_xfer) w_next = ST_SEND_ALU;
      end
      ST_SEND_ALU: begin
        w_push     = w_slotFree;
        w_pushTag  = TAG_ALU;
        w_pushData = r_aluSnap;
        if (w_xfer) w_next = (r_first > r_last) ? w_afterLast : ST_READ_REG;
      end
      ST_READ_REG: begin
        w_next = ST_SEND_REG;
      end
      ST_SEND_REG: begin
        w_push     = w_slotFree;
        w_pushTag  = regTag(8'(r_idx));
        w_pushData = r_regData;
        if (w_xfer) w_next = (r_idx == r_last) ? w_afterLast : ST_READ_REG;
      end
`ifdef REG_DUMP_CHECKSUM_EN
      ST_SEND_CSUM: begin
        w_push     = w_slotFree;
        w_pushTag  = TAG_CSUM;
        w_pushData = r_csum;
        if (w_xfer) w_next = ST_FINISH;
      end
`endif
      ST_FINISH: begin
        w_next = ST_DONE;
      end
      ST_DONE: begin
        if (arm) w_next = ST_ARMED;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Configuration capture at arm, snapshot at the trigger edge, and the
  // register walk. The index stops at last_reg so it never wraps past 31.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig    <= '0;
      r_first   <= '0;
      r_last    <= '0;
      r_idx     <= '0;
      r_pcSnap  <= '0;
      r_aluSnap <= '0;
      r_regData <= '0;
    end else begin
      if (w_armAccept) begin
        r_trig  <= trig_cycle;
        r_first <= first_reg;
        r_last  <= last_reg;
      end
      if (w_fire) begin
        r_pcSnap  <= pc_in;
        r_aluSnap <= aluout_in;
        r_idx     <= r_first;
      end
      if (r_state == ST_READ_REG) begin
        r_regData <= rf_rd_data;
      end
      if ((r_state == ST_SEND_REG) && w_xfer && (r_idx != r_last)) begin
        r_idx <= r_idx + ADDR_W'(1);
      end
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  // Running XOR of every payload pushed in this dump, restarted at the
  // trigger; the checksum beat itself is not folded in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum <= '0;
    end else if (w_fire) begin
      r_csum <= '0;
    end else if (w_push && (r_state != ST_SEND_CSUM)) begin
      r_csum <= r_csum ^ w_pushData;
    end
  end
`endif

  dump_out_reg #(
    .DATA_W (DATA_W)
  ) u_outReg (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_push),
    .i_tag   (w_pushTag),
    .i_data  (w_pushData),
    .o_ready (w_bufReady),
    .o_valid (dump_valid),
    .o_tag   (dump_tag),
    .o_data  (dump_data),
    .i_ready (dump_ready)
  );

  assign rf_rd_addr  = r_idx;
  assign cycle_count = r_cycle;
  assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done        = (r_state == ST_FINISH);

endmodule
